mem_control: RTL
================

Name: mem_control

Overview:
- Memory-side controller that sits directly downstream of the input/output control stage.
- Accepts read, write and clear commands over a level handshake and executes them against an internal 32-bit word array.
- Returns read data and a done flag that the IO stage polls.
- Emulates a multi-cycle memory so the IO stage's wait logic is exercised.

Parameters:
- DEPTH, 256, number of 32-bit words in the array (power of two, ≥2).
- READ_LAT, 2, cycles from command accept to read data valid (≥1).
- AW, $clog2(DEPTH), derived index width; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rstN  input  1  asynchronous active-low reset.
- memCmd  input  2  command: 00 nop, 01 read, 10 write, 11 clear-all.
- ioDataIn  input  32  write data from the IO stage.
- memAddrIn  input  64  word address from the IO stage.
- ioCmdDoneIn  input  1  IO stage asserts when memCmd, address and data are stable.
- memCmdDoneOut  output  1  high = idle/finished; low = busy.
- memDataOut  output  32  read result, held until the next successful read.
- memErr  output  1  last accepted command had an out-of-range address.

Behaviour:
- Reset (async assert, sync release): state IDLE; memCmdDoneOut=1; memDataOut=0; memErr=0; armed=1; clear counter=0. Array contents are not reset.
- Armed flag: cleared on accept; set on any edge where ioCmdDoneIn=0. A held-high ioCmdDoneIn therefore issues exactly one command.
- Accept condition: state IDLE && armed && ioCmdDoneIn=1 && memCmd≠00. On the accept edge T:
  - latch cmd, data and address;
  - clear memErr;
  - memCmdDoneOut goes low after edge T.
- nop with ioCmdDoneIn=1 is ignored. armed stays set and nothing changes.
- Range check: out of range when memAddrIn[63:AW]≠0.
  - Applies to read and write only; clear ignores the address.
  - On out of range: memErr=1, no array access, memDataOut unchanged. Goes to DONE at T+1; memCmdDoneOut is high after edge T+1.
- States: IDLE, READ_WAIT, WRITE, CLEAR, DONE.
  - IDLE -> READ_WAIT / WRITE / CLEAR on accept.
  - READ_WAIT: latency counter counts READ_LAT edges from T. On the last edge, memDataOut=array[addr] and the FSM goes to DONE. memCmdDoneOut is high after edge T+READ_LAT+1. memDataOut is updated coincident with or before done rises.
  - WRITE: array[addr]=data on edge T+1 -> DONE. memCmdDoneOut is high after T+2.
  - CLEAR: writes 0 to index 0..DEPTH-1, one word per edge starting T+1. Last write at T+DEPTH, then DONE. memCmdDoneOut is high after T+DEPTH+1. Counter wraps to 0 at the end.
  - DONE: memCmdDoneOut=1 -> IDLE on the next edge. New commands are accepted from IDLE only, so the minimum command spacing is one idle cycle after done.
- memCmdDoneOut is a registered output, 1 in IDLE and DONE, 0 otherwise.
- Input changes while busy (memCmd, address, data, ioCmdDoneIn) are ignored; latched values are used. A drop of ioCmdDoneIn while busy re-arms for the next command.
- Reset mid-operation aborts immediately and outputs return to reset values:
  - an in-flight write may or may not land;
  - a partial clear leaves words 0..k-1 zeroed and the rest intact.
- Read of a never-written word returns X in simulation. Benches must write or clear first.

Test Plan:
- Write 32'hDEADBEEF to addr 5, then read addr 5 (READ_LAT=2) -> memCmdDoneOut low 3 cycles after read accept, memDataOut=32'hDEADBEEF when done rises, memErr=0.
- Read with memAddrIn=64'h100, DEPTH=256 -> memErr=1 after T+1, memDataOut keeps its previous value, done high after T+1. A following valid read clears memErr.
- Write 32'h1234 to addrs 0 and 255, issue clear (11), read both -> done low exactly DEPTH+1 cycles after accept; both reads return 0.
- Hold ioCmdDoneIn=1 for 20 cycles with memCmd=10, addr 7, data 32'hA5A5A5A5 -> exactly one write accepted. Drop to 0 and raise with read addr 7 -> second command accepted, returns 32'hA5A5A5A5.
- Pulse rstN low at clear cycle 10 -> memCmdDoneOut=1, memErr=0, memDataOut=0 immediately. Words 0..9 read 0, words ≥10 keep prior values.
- Change memCmd/address/data during READ_WAIT -> result reflects the latched address; no extra command is started.

Source files
------------

// File: rtl/mem_control_if.sv
// mem_control_if: command/response bundle between the IO stage (master) and mem_control (slave).
interface mem_control_if;
    logic [1:0]  memCmd;
    logic [31:0] ioDataIn;
    logic [63:0] memAddrIn;
    logic        ioCmdDoneIn;
    logic        memCmdDoneOut;
    logic [31:0] memDataOut;
    logic        memErr;
    modport master (output memCmd, ioDataIn, memAddrIn, ioCmdDoneIn, input memCmdDoneOut, memDataOut, memErr);
    modport slave (input memCmd, ioDataIn, memAddrIn, ioCmdDoneIn, output memCmdDoneOut, memDataOut, memErr);
endinterface

// File: rtl/mem_control.sv
// mem_control: multi-cycle word memory executing read/write/clear-all commands from a level handshake.
module mem_control #(
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 2
) (
    input logic          clk,
    input logic          rstN,
    mem_control_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(READ_LAT + 1);
    typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE, CLEAR, DONE} state_t;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  clr_q, clr_d;
    logic [63:0]    addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic           armed_q, armed_d;
    logic           we;
    logic [AW-1:0]  wa;
    logic [31:0]    wd;
    logic [31:0]    mem [DEPTH];
    logic           bad;
    logic           accept;
    assign bad    = |addr_q[63:AW];
    assign accept = state_q == IDLE && armed_q && bus.ioCmdDoneIn && bus.memCmd != 2'b00;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        done_d  = done_q;
        armed_d = bus.ioCmdDoneIn ? armed_q : 1'b1;
        we      = 1'b0;
        wa      = addr_q[AW-1:0];
        wd      = data_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b1;
                if (accept) begin
                    armed_d = 1'b0;
                    addr_d  = bus.memAddrIn;
                    data_d  = bus.ioDataIn;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = bus.memCmd == 2'b01 ? READ_WAIT : bus.memCmd == 2'b10 ? WRITE : CLEAR;
                end
            end
            READ_WAIT: begin
                if (bad) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CW'(READ_LAT - 1)) begin
                    rdata_d = mem[addr_q[AW-1:0]];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WRITE: begin
                err_d   = bad;
                done_d  = bad;
                we      = !bad;
                state_d = DONE;
            end
            CLEAR: begin
                we      = 1'b1;
                wa      = clr_q;
                wd      = '0;
                clr_d   = clr_q + AW'(1);
                state_d = clr_q == AW'(DEPTH - 1) ? DONE : CLEAR;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            clr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            done_q  <= done_d;
            armed_q <= armed_d;
        end
    end
    // Array has no reset; an aborted clear leaves untouched words intact.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end
    assign bus.memCmdDoneOut = done_q;
    assign bus.memDataOut    = rdata_q;
    assign bus.memErr        = err_q;
endmodule
